// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory port arbiter: FSM states, bus direction
// values and the fixed requester slot assignment.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ADDR   = 2'b01,
        ACCESS = 2'b10,
        DONE   = 2'b11
    } state_t;

    localparam logic MEM_READ  = 1'b1;
    localparam logic MEM_WRITE = 1'b0;

    localparam int REQ_FETCH = 32'd0;
    localparam int REQ_LSU   = 32'd1;
    localparam int REQ_DMA   = 32'd2;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit at or above ptr,
// wrapping past NREQ-1 back to slot 0.
module rr_pick #(
    parameter int NREQ = 3,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] onehot,
    output logic [IW-1:0]   idx,
    output logic            valid
);

    logic [IW:0]   sum_s;
    logic [IW-1:0] pos_s;
    logic          take_s;

    // scan slots in rotation order; the first hit wins and masks later ones
    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        sum_s  = '0;
        pos_s  = '0;
        take_s = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            sum_s  = {1'b0, ptr} + (IW+1)'(i);
            pos_s  = (sum_s >= (IW+1)'(NREQ)) ? IW'(sum_s - (IW+1)'(NREQ)) : IW'(sum_s);
            take_s = req[pos_s] & ~valid;
            onehot[pos_s] = onehot[pos_s] | take_s;
            idx    = take_s ? pos_s : idx;
            valid  = valid | take_s;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin owner of the single memory port: grants one requester, runs the
// address-setup / MFC-wait sequence with timeout, and returns data plus a done pulse.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    we,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    done,
    output logic [DW-1:0]      rdata,
    output logic               err,
    output logic               mem_en,
    output logic               mem_rw,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_wdata,
    input  logic [DW-1:0]      mem_rdata,
    input  logic               mem_mfc
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = 8;

    state_t          state_r, state_s;
    logic [CW-1:0]   cnt_r, cnt_s;
    logic [IW-1:0]   rr_ptr_r, rr_ptr_s;
    logic [IW-1:0]   win_idx_r, win_idx_s;
    logic [NREQ-1:0] gnt_r, gnt_s;
    logic [NREQ-1:0] done_r, done_s;
    logic [DW-1:0]   rdata_r, rdata_s;
    logic            err_r, err_s;
    logic            mem_en_r, mem_en_s;
    logic            mem_rw_r, mem_rw_s;
    logic [AW-1:0]   mem_addr_r, mem_addr_s;
    logic [DW-1:0]   mem_wdata_r, mem_wdata_s;

    logic [NREQ-1:0] pick_onehot_s;
    logic [IW-1:0]   pick_idx_s;
    logic            pick_valid_s;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req    (req),
        .ptr    (rr_ptr_r),
        .onehot (pick_onehot_s),
        .idx    (pick_idx_s),
        .valid  (pick_valid_s)
    );

    // next-state and next-output logic; every output is taken from a register
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        rr_ptr_s    = rr_ptr_r;
        win_idx_s   = win_idx_r;
        gnt_s       = gnt_r;
        done_s      = done_r;
        rdata_s     = rdata_r;
        err_s       = err_r;
        mem_en_s    = mem_en_r;
        mem_rw_s    = mem_rw_r;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        case (state_r)
            IDLE: begin
                if (pick_valid_s) begin
                    win_idx_s   = pick_idx_s;
                    gnt_s       = pick_onehot_s;
                    mem_addr_s  = addr[int'(pick_idx_s)*AW +: AW];
                    mem_wdata_s = wdata[int'(pick_idx_s)*DW +: DW];
                    mem_rw_s    = we[pick_idx_s] ? MEM_WRITE : MEM_READ;
                    err_s       = 1'b0;
                    mem_en_s    = 1'b0;
                    state_s     = ADDR;
                end else begin
                    state_s = IDLE;
                end
            end
            ADDR: begin
                mem_en_s = 1'b1;
                cnt_s    = '0;
                state_s  = ACCESS;
            end
            ACCESS: begin
                if (mem_mfc) begin
                    rdata_s  = (mem_rw_r == MEM_READ) ? mem_rdata : rdata_r;
                    mem_en_s = 1'b0;
                    done_s   = gnt_r;
                    state_s  = DONE;
                end else if (cnt_r == CW'(TIMEOUT - 1)) begin
                    // MFC never came: abort with the error flag, data untouched
                    err_s    = 1'b1;
                    mem_en_s = 1'b0;
                    done_s   = gnt_r;
                    state_s  = DONE;
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            DONE: begin
                done_s   = '0;
                gnt_s    = '0;
                rr_ptr_s = (win_idx_r == IW'(NREQ - 1)) ? '0 : win_idx_r + IW'(1);
                state_s  = IDLE;
            end
            default: begin
                state_s  = IDLE;
                gnt_s    = '0;
                done_s   = '0;
                mem_en_s = 1'b0;
            end
        endcase
    end

    // state and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            rr_ptr_r    <= '0;
            win_idx_r   <= '0;
            gnt_r       <= '0;
            done_r      <= '0;
            rdata_r     <= '0;
            err_r       <= 1'b0;
            mem_en_r    <= 1'b0;
            mem_rw_r    <= MEM_READ;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            rr_ptr_r    <= rr_ptr_s;
            win_idx_r   <= win_idx_s;
            gnt_r       <= gnt_s;
            done_r      <= done_s;
            rdata_r     <= rdata_s;
            err_r       <= err_s;
            mem_en_r    <= mem_en_s;
            mem_rw_r    <= mem_rw_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
        end
    end

    assign gnt       = gnt_r;
    assign done      = done_r;
    assign rdata     = rdata_r;
    assign err       = err_r;
    assign mem_en    = mem_en_r;
    assign mem_rw    = mem_rw_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (TIMEOUT overridden to 8).
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic [2:0]  req;
    logic [2:0]  we;
    logic [47:0] addr;
    logic [47:0] wdata;
    logic [2:0]  gnt;
    logic [2:0]  done;
    logic [15:0] rdata;
    logic        err;
    logic        mem_en;
    logic        mem_rw;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_mfc;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(.NREQ(3), .AW(16), .DW(16), .TIMEOUT(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .done      (done),
        .rdata     (rdata),
        .err       (err),
        .mem_en    (mem_en),
        .mem_rw    (mem_rw),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_mfc   (mem_mfc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if ({gnt, done, rdata, err, mem_en, mem_rw, mem_addr, mem_wdata} !== {3'b000, 3'b000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000}) begin
            bad++;
            $display("FAIL reset_values: got gnt=%b done=%b rdata=%h err=%b en=%b rw=%b addr=%h wd=%h, need all zero with rw=1",
                     gnt, done, rdata, err, mem_en, mem_rw, mem_addr, mem_wdata);
        end
        rst = 1'b0;
        step();
        total++;
        if (gnt !== 3'b000) begin bad++; $display("FAIL idle_no_req_gnt: got %b need 000", gnt); end
    endtask

    task automatic test_fetch_read();
        addr[15:0] = 16'h0040;
        req = 3'b001;
        step();
        total++;
        if (gnt !== 3'b001 || mem_addr !== 16'h0040 || mem_rw !== 1'b1 || mem_en !== 1'b0) begin
            bad++;
            $display("FAIL fetch_addr_phase: got gnt=%b addr=%h rw=%b en=%b need 001/0040/1/0", gnt, mem_addr, mem_rw, mem_en);
        end
        step();
        total++;
        if (mem_en !== 1'b1) begin bad++; $display("FAIL fetch_access_en: got %b need 1", mem_en); end
        step();
        mem_mfc = 1'b1;
        mem_rdata = 16'hBEEF;
        total++;
        if (done !== 3'b000) begin bad++; $display("FAIL fetch_early_done: got %b need 000", done); end
        step();
        mem_mfc = 1'b0;
        req = 3'b000;
        total++;
        if (done !== 3'b001 || rdata !== 16'hBEEF || err !== 1'b0 || mem_en !== 1'b0) begin
            bad++;
            $display("FAIL fetch_done: got done=%b rdata=%h err=%b en=%b need 001/BEEF/0/0", done, rdata, err, mem_en);
        end
        step();
        total++;
        if (done !== 3'b000 || gnt !== 3'b000) begin
            bad++;
            $display("FAIL fetch_release: got done=%b gnt=%b need 000/000", done, gnt);
        end
    endtask

    task automatic test_contention();
        logic [2:0] order [4];
        order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001;
        do_reset();
        we = 3'b000;
        req = 3'b111;
        for (int t = 0; t < 4; t++) begin
            step();
            total++;
            if (gnt !== order[t]) begin bad++; $display("FAIL contention_grant%0d: got %b need %b", t, gnt, order[t]); end
            step();
            mem_mfc = 1'b1;
            mem_rdata = 16'h1000 + 16'(t);
            total++;
            if (gnt !== order[t] || mem_en !== 1'b1) begin
                bad++;
                $display("FAIL contention_access%0d: got gnt=%b en=%b need %b/1", t, gnt, mem_en, order[t]);
            end
            step();
            mem_mfc = 1'b0;
            total++;
            if (done !== order[t] || rdata !== 16'h1000 + 16'(t)) begin
                bad++;
                $display("FAIL contention_done%0d: got done=%b rdata=%h need %b/%h", t, done, rdata, order[t], 16'h1000 + 16'(t));
            end
            if (t == 3) req = 3'b000;
            step();
            total++;
            if (gnt !== 3'b000 || done !== 3'b000) begin
                bad++;
                $display("FAIL contention_gap%0d: got gnt=%b done=%b need 000/000", t, gnt, done);
            end
        end
    endtask

    task automatic test_dma_write();
        addr[47:32]  = 16'h1234;
        wdata[47:32] = 16'h00AA;
        we  = 3'b100;
        req = 3'b100;
        step();
        addr[47:32]  = 16'h5555;
        wdata[47:32] = 16'h7777;
        we = 3'b000;
        total++;
        if (gnt !== 3'b100 || mem_rw !== 1'b0 || mem_addr !== 16'h1234 || mem_wdata !== 16'h00AA) begin
            bad++;
            $display("FAIL dma_addr_phase: got gnt=%b rw=%b addr=%h wd=%h need 100/0/1234/00AA", gnt, mem_rw, mem_addr, mem_wdata);
        end
        step();
        mem_mfc = 1'b1;
        mem_rdata = 16'hDEAD;
        total++;
        if (mem_en !== 1'b1 || mem_rw !== 1'b0 || mem_wdata !== 16'h00AA || mem_addr !== 16'h1234) begin
            bad++;
            $display("FAIL dma_access_hold: got en=%b rw=%b wd=%h addr=%h need 1/0/00AA/1234", mem_en, mem_rw, mem_wdata, mem_addr);
        end
        step();
        mem_mfc = 1'b0;
        req = 3'b000;
        total++;
        if (done !== 3'b100 || rdata !== 16'h1003 || err !== 1'b0) begin
            bad++;
            $display("FAIL dma_done: got done=%b rdata=%h err=%b need 100/1003/0", done, rdata, err);
        end
        step();
    endtask

    task automatic test_timeout();
        int en_cycles;
        bit finished;
        en_cycles = 0;
        finished = 1'b0;
        req = 3'b010;
        step();
        total++;
        if (gnt !== 3'b010) begin bad++; $display("FAIL timeout_grant: got %b need 010", gnt); end
        for (int c = 0; c < 20; c++) begin
            step();
            if (done !== 3'b000) begin
                finished = 1'b1;
                break;
            end
            if (mem_en === 1'b1) en_cycles++;
        end
        req = 3'b000;
        total++;
        if (!finished || en_cycles != 8 || done !== 3'b010 || err !== 1'b1 || rdata !== 16'h1003) begin
            bad++;
            $display("FAIL timeout_abort: got finished=%0d en_cycles=%0d done=%b err=%b rdata=%h need 1/8/010/1/1003",
                     finished, en_cycles, done, err, rdata);
        end
        step();
        req = 3'b001;
        step();
        total++;
        if (gnt !== 3'b001 || err !== 1'b0) begin
            bad++;
            $display("FAIL timeout_next_grant: got gnt=%b err=%b need 001/0", gnt, err);
        end
        step();
        mem_mfc = 1'b1;
        mem_rdata = 16'h2222;
        step();
        mem_mfc = 1'b0;
        req = 3'b000;
        total++;
        if (done !== 3'b001 || err !== 1'b0 || rdata !== 16'h2222) begin
            bad++;
            $display("FAIL timeout_next_done: got done=%b err=%b rdata=%h need 001/0/2222", done, err, rdata);
        end
        step();
    endtask

    task automatic test_reset_mid();
        req = 3'b001;
        step();
        step();
        total++;
        if (mem_en !== 1'b1) begin bad++; $display("FAIL rstmid_pre_en: got %b need 1", mem_en); end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (mem_en !== 1'b0 || gnt !== 3'b000 || done !== 3'b000) begin
            bad++;
            $display("FAIL rstmid_async: got en=%b gnt=%b done=%b need 0/000/000", mem_en, gnt, done);
        end
        step();
        rst = 1'b0;
        req = 3'b010;
        step();
        total++;
        if (gnt !== 3'b010) begin bad++; $display("FAIL rstmid_regrant: got %b need 010", gnt); end
        step();
        mem_mfc = 1'b1;
        step();
        mem_mfc = 1'b0;
        req = 3'b000;
        total++;
        if (done !== 3'b010) begin bad++; $display("FAIL rstmid_done: got %b need 010", done); end
        step();
    endtask

    task automatic test_withdrawn();
        mem_mfc = 1'b1;
        req = 3'b010;
        #3;
        req = 3'b000;
        step();
        total++;
        if (gnt !== 3'b000 || mem_en !== 1'b0 || done !== 3'b000) begin
            bad++;
            $display("FAIL withdrawn_no_grant: got gnt=%b en=%b done=%b need 000/0/000", gnt, mem_en, done);
        end
        req = 3'b010;
        step();
        total++;
        if (gnt !== 3'b010 || mem_en !== 1'b0) begin
            bad++;
            $display("FAIL withdrawn_grant: got gnt=%b en=%b need 010/0", gnt, mem_en);
        end
        step();
        mem_mfc = 1'b0;
        req = 3'b000;
        total++;
        if (mem_en !== 1'b1 || done !== 3'b000) begin
            bad++;
            $display("FAIL withdrawn_access: got en=%b done=%b need 1/000", mem_en, done);
        end
        step();
        mem_mfc = 1'b1;
        step();
        mem_mfc = 1'b0;
        total++;
        if (done !== 3'b010) begin bad++; $display("FAIL withdrawn_done: got %b need 010", done); end
        step();
        total++;
        if (done !== 3'b000 || gnt !== 3'b000) begin
            bad++;
            $display("FAIL withdrawn_idle: got done=%b gnt=%b need 000/000", done, gnt);
        end
    endtask

    initial begin
        rst = 1'b1;
        req = 3'b000;
        we = 3'b000;
        addr = '0;
        wdata = '0;
        mem_rdata = 16'h0000;
        mem_mfc = 1'b0;
        #2;
        test_reset();
        test_fetch_read();
        test_contention();
        test_dma_write();
        test_timeout();
        test_reset_mid();
        test_withdrawn();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory port (address, data, enable, read/write, memory-function-complete) between three requesters: instruction fetch (index 0), load/store execute (index 1) and DMA (index 2).
- Selects one requester round-robin and sequences the complete memory transaction, including the MFC wait and a timeout.
- Returns read data and a one-cycle completion pulse to the winner.
- Sits between the fetch/execute FSMs and the MAR/MDR/memory interface.

Parameters:
- NREQ, 3, number of requesters; index 0 has top priority after reset.
- AW, 16, address width.
- DW, 16, data width.
- TIMEOUT, 255, maximum cycles in ACCESS waiting for MFC before aborting (range 2..255).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester transaction request, level.
- we  in  NREQ  per-requester write enable (1 = write, 0 = read).
- addr  in  NREQ*AW  packed requester addresses; requester i occupies bits [i*AW +: AW].
- wdata  in  NREQ*DW  packed requester write data.
- gnt  out  NREQ  one-hot grant, held from ADDR through DONE.
- done  out  NREQ  one-hot, one-cycle completion pulse.
- rdata  out  DW  read data, valid in the done cycle and held until the next capture.
- err  out  1  timeout flag, valid in the done cycle.
- mem_en  out  1  memory enable.
- mem_rw  out  1  1 = read, 0 = write.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data.
- mem_mfc  in  1  memory function complete.

Behaviour:
- All outputs are registered.
- Reset values: gnt=0, done=0, rdata=0, err=0, mem_en=0, mem_rw=1, mem_addr=0, mem_wdata=0. Additionally state=IDLE, rr_ptr=0, timeout count=0.
- States: IDLE, ADDR, ACCESS, DONE.
- IDLE:
  - If any req bit is high at edge k, pick the winner as the first set bit searching from rr_ptr upward with wrap.
  - At edge k, latch the winner's addr, wdata and we into mem_addr, mem_wdata and mem_rw=~we. Set gnt[winner]=1, clear err, go to ADDR.
  - With no request, stay in IDLE with all outputs held.
- ADDR: mem_en=0 for exactly one cycle (address setup). Next edge: mem_en=1, count=0, go to ACCESS.
- ACCESS:
  - mem_en=1 and mem_rw are held stable. mem_mfc is sampled each edge.
  - mfc=1: capture rdata=mem_rdata (reads only; writes leave rdata unchanged), mem_en=0, done[winner]=1, go to DONE.
  - mfc=0: count increments. On the edge where count reaches TIMEOUT-1 with mfc still 0: err=1, mem_en=0, done[winner]=1, go to DONE; rdata is unchanged.
- DONE: lasts one cycle. Next edge: done=0, gnt=0, rr_ptr=(winner+1) mod NREQ, go to IDLE.
- Latency: a request seen at edge k produces a done pulse after edge k+1+m, where m≥1 is the number of ACCESS cycles. The port is back in IDLE at edge k+2+m. Minimum req-to-done is 3 edges.
- Arbitration:
  - Non-preemptive: no new grant is issued until IDLE.
  - A requester that keeps req high through DONE re-competes in IDLE, but rotation means others are served first.
  - Simultaneous requests are resolved purely by rr_ptr order; no starvation is possible with NREQ waiting.
- Boundary conditions:
  - req dropped before it is sampled in IDLE: never granted.
  - req dropped after grant: the transaction completes and done still pulses.
  - addr, wdata and we changing after grant: ignored, because they were latched in IDLE.
  - mfc high while in IDLE, ADDR or DONE: ignored.
  - Reset mid-transaction: mem_en, gnt and done drop immediately (asynchronous), with no done pulse. The transaction is lost and the requester must re-request.
  - Back-to-back transactions: a minimum of one IDLE cycle separates them.

Decomposition:
- Package mem_arb_pkg holds:
  - state encoding IDLE=2'b00, ADDR=2'b01, ACCESS=2'b10, DONE=2'b11;
  - constants MEM_READ=1'b1 and MEM_WRITE=1'b0;
  - requester index constants REQ_FETCH=0, REQ_LSU=1, REQ_DMA=2.
- One combinational sub-module, rr_pick:
  - inputs req[NREQ] and ptr;
  - outputs a one-hot winner, its index, and a valid flag.

Test Plan:
- Fetch read: req=3'b001, addr0=16'h0040, mfc asserted in the 2nd ACCESS cycle with mem_rdata=16'hBEEF -> gnt=001, mem_addr=0040, mem_rw=1, done=001 after exactly 4 edges, rdata=BEEF, err=0.
- Contention: req=3'b111 held, mfc asserted on the 1st ACCESS cycle -> grant order 001, 010, 100, 001; rr_ptr wraps; gnt stays one-hot throughout.
- DMA write: req=100, we=100, addr2=16'h1234, wdata2=16'h00AA -> mem_rw=0, mem_wdata=00AA during ACCESS, done=100, rdata unchanged from the previous value.
- Timeout: TIMEOUT=8, mfc held 0 -> mem_en high for 8 cycles, then done pulse with err=1; next request is granted normally with err=0.
- Reset mid-ACCESS: assert rst between edges -> mem_en, gnt and done go to 0 before the next edge; after release, req=010 is granted first because rr_ptr=0 and only index 1 is requesting.
- Request withdrawn: req1 pulsed low before the IDLE sample -> no grant. req1 dropped during ACCESS -> done=010 still pulses.
